// File: rtl/player_ctl_if.sv
// Player controller bus: timing/button inputs toward the block, sprite and shot outputs back.
interface player_ctl_if;
  logic        vblnk_in;
  logic        btn_left;
  logic        btn_right;
  logic        btn_fire;
  logic [11:0] xpos;
  logic        shot_req;
  logic [11:0] shot_x;

  modport slave  (input  vblnk_in, btn_left, btn_right, btn_fire,
                  output xpos, shot_req, shot_x);
  modport master (output vblnk_in, btn_left, btn_right, btn_fire,
                  input  xpos, shot_req, shot_x);
endinterface

// File: rtl/player_ctl.sv
// Player sprite controller: per-frame horizontal movement with saturation and a
// rate-limited fire FSM that emits a one-cycle shot request.
module player_ctl #(
  parameter int STEP     = 4,
  parameter int X_INIT   = 400,
  parameter int X_MAX    = 976,
  parameter int COOLDOWN = 16,
  parameter int SHOT_OFS = 22
) (
  input logic          pclk,
  input logic          rst,
  player_ctl_if.slave  bus
);
  localparam logic [11:0] STEP_W  = 12'(STEP);
  localparam logic [11:0] XINIT_W = 12'(X_INIT);
  localparam logic [11:0] XMAX_W  = 12'(X_MAX);
  localparam logic [11:0] XLIM_W  = 12'(X_MAX - STEP);
  localparam logic [11:0] OFS_W   = 12'(SHOT_OFS);
  localparam logic [4:0]  CD_W    = 5'(COOLDOWN);

  typedef enum logic [1:0] {S_READY, S_FIRE, S_COOLDOWN} state_t;

  // bit order {fire, right, left}
  logic [2:0]  btn_meta_q, btn_meta_d;
  logic [2:0]  btn_sync_q, btn_sync_d;
  logic        vblnk_q, vblnk_d;
  logic        armed_q, armed_d;
  logic [11:0] xpos_q, xpos_d;
  logic        frame_tick;
  logic        left_sync, right_sync, fire_sync;

  state_t      state_q;
  logic [4:0]  cd_cnt_q;
  logic        shot_req_q;
  logic [11:0] shot_x_q;

  assign left_sync  = btn_sync_q[0];
  assign right_sync = btn_sync_q[1];
  assign fire_sync  = btn_sync_q[2];

  // armed_q masks the first post-reset cycle, where vblnk_q is still forced low
  assign frame_tick = armed_q & bus.vblnk_in & ~vblnk_q;

  always_comb begin
    btn_meta_d = {bus.btn_fire, bus.btn_right, bus.btn_left};
    btn_sync_d = btn_meta_q;
    vblnk_d    = bus.vblnk_in;
    armed_d    = 1'b1;
    xpos_d     = xpos_q;
    if (frame_tick) begin
      case ({right_sync, left_sync})
        2'b01:   xpos_d = (xpos_q < STEP_W) ? 12'd0 : xpos_q - STEP_W;
        2'b10:   xpos_d = (xpos_q > XLIM_W) ? XMAX_W : xpos_q + STEP_W;
        default: xpos_d = xpos_q;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      vblnk_q    <= 1'b0;
      armed_q    <= 1'b0;
      xpos_q     <= XINIT_W;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      vblnk_q    <= vblnk_d;
      armed_q    <= armed_d;
      xpos_q     <= xpos_d;
    end
  end

  // shot_req/shot_x are registered alongside the FIRE transition so they are
  // visible exactly while the FSM sits in FIRE, using the post-move xpos
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q    <= S_READY;
      cd_cnt_q   <= 5'd0;
      shot_req_q <= 1'b0;
      shot_x_q   <= 12'd0;
    end else begin
      shot_req_q <= 1'b0;
      case (state_q)
        S_READY: begin
          if (frame_tick && fire_sync) begin
            state_q    <= S_FIRE;
            shot_req_q <= 1'b1;
            shot_x_q   <= xpos_d + OFS_W;
          end
        end
        S_FIRE: begin
          state_q  <= S_COOLDOWN;
          cd_cnt_q <= CD_W;
        end
        S_COOLDOWN: begin
          if (frame_tick) begin
            if (cd_cnt_q == 5'd1) state_q <= S_READY;
            else                  cd_cnt_q <= cd_cnt_q - 5'd1;
          end
        end
        default: state_q <= S_READY;
      endcase
    end
  end

  assign bus.xpos     = xpos_q;
  assign bus.shot_req = shot_req_q;
  assign bus.shot_x   = shot_x_q;
endmodule

// File: tb/tb_player_ctl.sv
// Directed bench for player_ctl: movement, saturation, fire cadence and reset behaviour.
module tb_player_ctl;
  logic pclk = 1'b0;
  logic rst  = 1'b0;
  player_ctl_if bus();

  player_ctl dut (.pclk(pclk), .rst(rst), .bus(bus));

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pre_x, post_x, tick_shot, tick_sx;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock, sample 1ns after the edge, count any shot pulse seen
  task automatic cyc();
    @(posedge pclk);
    #1;
    if (bus.shot_req) pulse_cnt++;
  endtask

  // 4 low cycles (enough for the 2-flop sync), then vblnk high for hi cycles
  task automatic frame(input int hi);
    bus.vblnk_in = 1'b0;
    repeat (4) cyc();
    pre_x = bus.xpos;
    bus.vblnk_in = 1'b1;
    cyc();
    tick_shot = bus.shot_req;
    tick_sx   = bus.shot_x;
    post_x    = bus.xpos;
    repeat (hi - 1) cyc();
    bus.vblnk_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.vblnk_in = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    bus.vblnk_in = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_fire = 1'b0;
    repeat (3) cyc();
    chk("rst_xpos", bus.xpos, 400);
    chk("rst_shot_req", bus.shot_req, 0);
    chk("rst_shot_x", bus.shot_x, 0);

    // release with vblnk already high: no tick until a fresh rising edge
    bus.vblnk_in = 1'b1; bus.btn_right = 1'b1; rst = 1'b1;
    repeat (6) cyc();
    chk("vblnk_high_at_release", bus.xpos, 400);
    bus.btn_right = 1'b0;
    bus.vblnk_in = 1'b0;
    repeat (3) cyc();

    // both directions: hold
    bus.btn_left = 1'b1; bus.btn_right = 1'b1;
    repeat (5) frame(1);
    chk("both_hold", bus.xpos, 400);
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;

    // single-cycle pin glitch is gone before the tick
    bus.vblnk_in = 1'b0;
    repeat (3) cyc();
    bus.btn_left = 1'b1; cyc(); bus.btn_left = 1'b0;
    frame(1);
    chk("short_pulse", bus.xpos, 400);

    // right for 10 frames; xpos moves only on ticks
    bus.btn_right = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      frame(1);
      chk($sformatf("right_pre%0d", k), pre_x, 400 + 4*(k-1));
      chk($sformatf("right_post%0d", k), post_x, 400 + 4*k);
    end
    chk("right_10", bus.xpos, 440);

    // climb to 972, then saturate at 976
    repeat (133) frame(1);
    chk("right_972", bus.xpos, 972);
    for (int k = 0; k < 3; k++) begin
      frame(1);
      chk($sformatf("sat_max%0d", k), bus.xpos, 976);
    end

    // left down to 4, then saturate at 0
    bus.btn_right = 1'b0; bus.btn_left = 1'b1;
    repeat (243) frame(1);
    chk("left_4", bus.xpos, 4);
    frame(1);
    chk("sat_min0", bus.xpos, 0);
    frame(1);
    chk("sat_min1", bus.xpos, 0);
    bus.btn_left = 1'b0;

    // fire held 40 frames while moving right
    do_reset();
    chk("rst_mid_xpos", bus.xpos, 400);
    bus.btn_fire = 1'b1; bus.btn_right = 1'b1;
    pulse_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      frame(1);
      if (k == 1 || k == 18 || k == 35) begin
        chk($sformatf("shot_tick%0d", k), tick_shot, 1);
        chk($sformatf("shot_x_tick%0d", k), tick_sx, 400 + 4*k + 22);
      end else begin
        chk($sformatf("no_shot_tick%0d", k), tick_shot, 0);
      end
      if (k == 10) chk("shot_x_hold", bus.shot_x, 426);
    end
    chk("fire_pulse_count", pulse_cnt, 3);
    bus.btn_right = 1'b0;

    // reset during cooldown aborts it
    do_reset();
    pulse_cnt = 0;
    frame(1);
    chk("abort_first_shot", tick_shot, 1);
    repeat (3) frame(1);
    chk("abort_cooldown_quiet", pulse_cnt, 1);
    do_reset();
    chk("abort_rst_shot_x", bus.shot_x, 0);
    chk("abort_rst_shot_req", bus.shot_req, 0);
    frame(1);
    chk("abort_shot_after", tick_shot, 1);
    chk("abort_shot_x_after", tick_sx, 422);
    chk("abort_pulse_count", pulse_cnt, 2);

    // vblnk high for a whole frame: one move, one shot
    do_reset();
    bus.btn_right = 1'b1;
    pulse_cnt = 0;
    frame(10);
    chk("long_vblnk_tick_shot", tick_shot, 1);
    chk("long_vblnk_xpos", bus.xpos, 404);
    chk("long_vblnk_pulses", pulse_cnt, 1);
    frame(1);
    chk("next_frame_xpos", bus.xpos, 408);
    chk("next_frame_no_shot", pulse_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
